// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. Two WIDTH-bit operands and a carry-in are
// summed one bit per clock, LSB first, using a single full-adder cell and a
// carry flip-flop. A start/busy/done handshake frames each operation.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..64), default 8
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (release synchronous to clk)
//   start  in   request; accepted in IDLE or DONE
//   a      in   operand A, captured when start is accepted
//   b      in   operand B, captured when start is accepted
//   cin    in   carry-in, captured when start is accepted
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  result, held until the next completed operation
//   cout   out  carry-out of bit WIDTH-1, held with sum
//   ovf    out  signed overflow, held with sum (only with the macro below)
//
// Configuration:
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its flop.
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [WIDTH-1:0]   r_shiftA;
    logic [WIDTH-1:0]   r_shiftB;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_bitSum;
    logic               w_bitCarry;
    logic [WIDTH-1:0]   w_nextResult;

    // A new operation can only be taken when no addition is in flight; in
    // DONE this gives back-to-back operation without an IDLE gap.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    // The counter holds the index of the bit being added this cycle, so the
    // final bit is processed when it equals WIDTH-1.
    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    // The single full-adder cell working on the current LSBs and the carry.
    assign w_bitSum   = r_shiftA[0] ^ r_shiftB[0] ^ r_carry;
    assign w_bitCarry = (r_shiftA[0] & r_shiftB[0])
                      | (r_shiftA[0] & r_carry)
                      | (r_shiftB[0] & r_carry);

    // Sum bits enter from the MSB end, so after WIDTH shifts bit 0 has
    // travelled all the way down to position 0.
    assign w_nextResult = {w_bitSum, r_result[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE waits for start, RUN counts out WIDTH bits,
    // DONE lasts one cycle and may immediately accept another start.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = start ? RUN : IDLE;
            RUN:     w_nextState = w_last ? DONE : RUN;
            DONE:    w_nextState = start ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register, so busy
    // rises on the accepting edge and done is high for the DONE cycle only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands on acceptance, then shift one bit per RUN
    // cycle. The visible result registers are written only on the last bit
    // edge so partial sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shiftA <= '0;
            r_shiftB <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_shiftA <= a;
            r_shiftB <= b;
            r_carry  <= cin;
            r_count  <= '0;
        end else if (r_state == RUN) begin
            r_shiftA <= {1'b0, r_shiftA[WIDTH-1:1]};
            r_shiftB <= {1'b0, r_shiftB[WIDTH-1:1]};
            r_result <= w_nextResult;
            r_carry  <= w_bitCarry;
            r_count  <= r_count + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_nextResult;
                r_cout <= w_bitCarry;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // During the last RUN cycle the carry flop still holds the carry into
    // the MSB (written on the previous edge), so XOR with the carry out of
    // the MSB gives two's-complement overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && (r_state == RUN) && w_last) begin
            r_ovf <= r_carry ^ w_bitCarry;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder at WIDTH=8. Directed cases cover the
// handshake, operand capture, back-to-back operation and mid-run reset;
// random operations are compared against plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the full WIDTH+1-bit unsigned sum.
    function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Reference: signed overflow from the carry into and out of the MSB,
    // each obtained by ordinary addition of the relevant bit fields.
    function automatic logic refOvf(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic             c);
        logic [WIDTH-1:0] low;
        logic [WIDTH:0]   full;
        low  = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]}
             + {{(WIDTH-1){1'b0}}, c};
        full = refSum(x, y, c);
        return low[WIDTH-1] ^ full[WIDTH];
    endfunction

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h",
                     tag, observed, expected);
        end
    endtask

    // Presents operands with start for one rising edge; returns at the
    // falling edge after acceptance.
    task automatic applyStimulus(input logic [WIDTH-1:0] ia,
                                 input logic [WIDTH-1:0] ib,
                                 input logic             ic);
        @(negedge clk);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting cycles waited and busy cycles seen.
    task automatic waitDone(input string tag, output int cycles,
                            output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busyCycles++;
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_done_seen"}, {63'd0, done}, 64'd1);
    endtask

    // Compares the held result against the reference model.
    task automatic checkResult(input string tag,
                               input logic [WIDTH-1:0] ea,
                               input logic [WIDTH-1:0] eb,
                               input logic             ec);
        logic [WIDTH:0] exp;
        exp = refSum(ea, eb, ec);
        checkOutput({tag, "_sum"},  {56'd0, sum},  {56'd0, exp[WIDTH-1:0]});
        checkOutput({tag, "_cout"}, {63'd0, cout}, {63'd0, exp[WIDTH]});
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({tag, "_ovf"},  {63'd0, ovf},
                    {63'd0, refOvf(ea, eb, ec)});
`endif
    endtask

    // Runs one isolated operation and checks latency, pulse width, result.
    task automatic runDirected(input string tag,
                               input logic [WIDTH-1:0] ia,
                               input logic [WIDTH-1:0] ib,
                               input logic             ic);
        int cycles;
        int busyCycles;
        applyStimulus(ia, ib, ic);
        waitDone(tag, cycles, busyCycles);
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(WIDTH));
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'(WIDTH));
        checkOutput({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        checkResult(tag, ia, ib, ic);
        @(negedge clk);
        checkOutput({tag, "_done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int cycles;
        int busyCycles;
        int extraDone;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        rst_n       = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_sum",  {56'd0, sum},  64'd0);
        checkOutput("reset_cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        runDirected("zero",   8'h00, 8'h00, 1'b0);
        runDirected("wrap",   8'hFF, 8'h01, 1'b0);
        runDirected("sgnovf", 8'h7F, 8'h01, 1'b0);
        runDirected("maxall", 8'hFF, 8'hFF, 1'b1);

        // Operand change and a second start during RUN must be ignored.
        applyStimulus(8'hA5, 8'h5A, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignore", cycles, busyCycles);
        checkResult("ignore", 8'hA5, 8'h5A, 1'b1);
        extraDone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extraDone++;
        end
        checkOutput("ignore_extra_done", 64'(extraDone), 64'd0);

        // Back-to-back: start held high through the DONE cycle.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        waitDone("b2b_first", cycles, busyCycles);
        checkResult("b2b_first", 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy_again", {63'd0, busy}, 64'd1);
        checkOutput("b2b_done_low",   {63'd0, done}, 64'd0);
        waitDone("b2b_second", cycles, busyCycles);
        checkOutput("b2b_gap", 64'(cycles + 1), 64'(WIDTH + 1));
        checkResult("b2b_second", 8'h10, 8'h20, 1'b0);

        // Reset in the middle of an operation.
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_done", {63'd0, done}, 64'd0);
        checkOutput("midrst_sum",  {56'd0, sum},  64'd0);
        checkOutput("midrst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extraDone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extraDone++;
        end
        checkOutput("midrst_no_activity", 64'(extraDone), 64'd0);
        runDirected("postrst", 8'hFF, 8'hFF, 1'b0);

        // Random operations, with operands scrambled after acceptance.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            applyStimulus(ra, rb, rc);
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            waitDone("rand", cycles, busyCycles);
            checkOutput("rand_latency", 64'(cycles), 64'(WIDTH));
            checkResult("rand", ra, rb, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
